// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg: shared state encoding, condition codes and instruction field layout
package datapath_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXECUTE, S_DONE} state_t;
  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;
  localparam int COND_LSB = 28;
  localparam int OP_LSB = 24;
  localparam int S_POS = 23;
  localparam int W_POS = 22;
  localparam int RD_LSB = 17;
  localparam int RN_LSB = 12;
  localparam int RM_LSB = 7;
  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;
endpackage

// File: rtl/datapath_ctrl_cond_check.sv
// cond_check: evaluates an ARM condition field against NZCV; odd codes invert their even partner
module cond_check
  import datapath_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);
  logic n, z, c, v, base;
  assign n = nzcv[N_IDX];
  assign z = nzcv[Z_IDX];
  assign c = nzcv[C_IDX];
  assign v = nzcv[V_IDX];
  always_comb begin
    base = 1'b1;
    case ({cond[3:1], 1'b0})
      COND_EQ: base = z;
      COND_CS: base = c;
      COND_MI: base = n;
      COND_VS: base = v;
      COND_HI: base = c & !z;
      COND_GE: base = n == v;
      COND_GT: base = !z & (n == v);
      default: base = 1'b1;
    endcase
    pass = base ^ cond[0];
  end
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: four-state sequencer driving register selects, ALU op and write enable, holding NZCV
module datapath_ctrl
  import datapath_ctrl_pkg::*;
#(
  parameter int NREG_BITS = 5,
  parameter int OP_BITS = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          instr,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  output logic [NREG_BITS-1:0] read_reg_num1,
  output logic [NREG_BITS-1:0] read_reg_num2,
  output logic [NREG_BITS-1:0] write_reg,
  output logic [OP_BITS-1:0]   alu_control,
  output logic                 regwrite,
  input  logic                 zero_flag,
  input  logic                 carry_flag,
  input  logic                 overflow_flag,
  input  logic                 negative_flag,
  output logic [3:0]           nzcv,
  output logic                 done,
  output logic                 executed
);
  state_t state;
  logic [3:0] cond_q;
  logic s_q, w_q, pass, cond_ok;
  logic unused_low_bits;
  assign unused_low_bits = ^instr[RM_LSB-1:0];
  assign instr_ready = state == S_IDLE;
  cond_check u_cond (.cond(cond_q), .nzcv(nzcv), .pass(cond_ok));
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S_IDLE;
      read_reg_num1 <= '0;
      read_reg_num2 <= '0;
      write_reg <= '0;
      alu_control <= '0;
      nzcv <= '0;
      cond_q <= '0;
      s_q <= 1'b0;
      w_q <= 1'b0;
      pass <= 1'b0;
      regwrite <= 1'b0;
      done <= 1'b0;
      executed <= 1'b0;
    end else begin
      regwrite <= 1'b0;
      done <= 1'b0;
      executed <= 1'b0;
      case (state)
        S_IDLE: if (instr_valid) begin
          cond_q <= instr[COND_LSB +: 4];
          alu_control <= instr[OP_LSB +: OP_BITS];
          s_q <= instr[S_POS];
          w_q <= instr[W_POS];
          write_reg <= instr[RD_LSB +: NREG_BITS];
          read_reg_num1 <= instr[RN_LSB +: NREG_BITS];
          read_reg_num2 <= instr[RM_LSB +: NREG_BITS];
          state <= S_DECODE;
        end
        S_DECODE: begin
          pass <= cond_ok;
          regwrite <= cond_ok & w_q;
          done <= !cond_ok;
          state <= cond_ok ? S_EXECUTE : S_DONE;
        end
        S_EXECUTE: begin
          if (s_q) nzcv <= {negative_flag, zero_flag, carry_flag, overflow_flag};
          done <= 1'b1;
          executed <= pass;
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: directed vector table, reset corner cases and random instructions against a flag model
module tb_datapath_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [31:0] instr = '0;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [4:0] read_reg_num1, read_reg_num2, write_reg;
  logic [3:0] alu_control;
  logic regwrite;
  logic zero_flag = 1'b0, carry_flag = 1'b0, overflow_flag = 1'b0, negative_flag = 1'b0;
  logic [3:0] nzcv;
  logic done, executed;
  int checks = 0;
  int failures = 0;
  logic [3:0] m_nzcv = '0;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  flags;
    logic        exec;
    logic        rw;
    logic [3:0]  nzcv;
  } vec_t;
  vec_t vecs[12];

  datapath_ctrl dut (
    .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .read_reg_num1(read_reg_num1), .read_reg_num2(read_reg_num2),
    .write_reg(write_reg), .alu_control(alu_control), .regwrite(regwrite),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .overflow_flag(overflow_flag),
    .negative_flag(negative_flag), .nzcv(nzcv), .done(done), .executed(executed)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk(input logic [3:0] cond, input logic [3:0] op, input logic s,
                                     input logic w, input logic [4:0] rd, input logic [4:0] rn,
                                     input logic [4:0] rm);
    return {cond, op, s, w, rd, rn, rm, 7'b0};
  endfunction

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input string name, input logic [31:0] w, input logic [3:0] f,
                     input logic exp_exec, input logic exp_rw, input logic [3:0] exp_nzcv);
    chk({name, "_ready_idle"}, instr_ready, 1);
    instr = w;
    instr_valid = 1'b1;
    {negative_flag, zero_flag, carry_flag, overflow_flag} = f;
    @(negedge clock);
    instr = $urandom;
    chk({name, "_ready_busy"}, instr_ready, 0);
    chk({name, "_sel"}, {read_reg_num1, read_reg_num2, write_reg, alu_control},
        {w[16:12], w[11:7], w[21:17], w[27:24]});
    chk({name, "_decode_ctl"}, {regwrite, done}, 0);
    if (exp_exec) begin
      @(negedge clock);
      instr = $urandom;
      chk({name, "_exec_rw"}, {regwrite, done}, {exp_rw, 1'b0});
      chk({name, "_exec_sel_hold"}, {read_reg_num1, read_reg_num2, write_reg, alu_control},
          {w[16:12], w[11:7], w[21:17], w[27:24]});
    end
    @(negedge clock);
    instr_valid = 1'b0;
    chk({name, "_done"}, {done, executed, regwrite}, {1'b1, exp_exec, 1'b0});
    chk({name, "_nzcv"}, nzcv, exp_nzcv);
    @(negedge clock);
    chk({name, "_after"}, {done, instr_ready, write_reg}, {1'b0, 1'b1, w[21:17]});
  endtask

  initial begin
    vecs[0]  = '{mk(4'hE, 4'h3, 1, 1, 2, 1, 3), 4'b1010, 1, 1, 4'b1010};
    vecs[1]  = '{mk(4'hE, 4'h2, 1, 0, 0, 4, 5), 4'b0100, 1, 0, 4'b0100};
    vecs[2]  = '{mk(4'h0, 4'h1, 0, 1, 6, 7, 8), 4'b1111, 1, 1, 4'b0100};
    vecs[3]  = '{mk(4'h1, 4'h4, 1, 1, 9, 2, 3), 4'b1111, 0, 0, 4'b0100};
    vecs[4]  = '{mk(4'hE, 4'h2, 1, 0, 0, 1, 1), 4'b1001, 1, 0, 4'b1001};
    vecs[5]  = '{mk(4'hA, 4'h5, 0, 1, 31, 30, 29), 4'b0000, 1, 1, 4'b1001};
    vecs[6]  = '{mk(4'hB, 4'h6, 1, 1, 3, 4, 5), 4'b0000, 0, 0, 4'b1001};
    vecs[7]  = '{mk(4'hE, 4'h2, 1, 0, 0, 2, 2), 4'b1000, 1, 0, 4'b1000};
    vecs[8]  = '{mk(4'hD, 4'h7, 0, 1, 10, 11, 12), 4'b0110, 1, 1, 4'b1000};
    vecs[9]  = '{mk(4'hC, 4'h8, 1, 1, 13, 14, 15), 4'b0110, 0, 0, 4'b1000};
    vecs[10] = '{mk(4'hF, 4'h9, 1, 1, 16, 17, 18), 4'b1111, 0, 0, 4'b1000};
    vecs[11] = '{mk(4'hE, 4'hA, 0, 0, 19, 20, 21), 4'b1111, 1, 0, 4'b1000};
    instr_valid = 1'b1;
    instr = mk(4'hE, 4'h3, 1, 1, 2, 1, 3);
    repeat (2) @(negedge clock);
    chk("reset_ctl", {nzcv, regwrite, done, executed}, 0);
    chk("reset_sel", {read_reg_num1, read_reg_num2, write_reg, alu_control}, 0);
    instr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    chk("reset_release_ready", instr_ready, 1);
    for (int i = 0; i < 12; i++) begin
      run($sformatf("vec%0d", i), vecs[i].word, vecs[i].flags, vecs[i].exec, vecs[i].rw, vecs[i].nzcv);
      m_nzcv = vecs[i].nzcv;
    end
    instr = mk(4'hE, 4'h5, 1, 1, 9, 10, 11);
    {negative_flag, zero_flag, carry_flag, overflow_flag} = 4'b1111;
    instr_valid = 1'b1;
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    chk("midrst_rw_before", regwrite, 1);
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_state", {regwrite, done, nzcv, write_reg}, 0);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_release", {instr_ready, done, nzcv}, {1'b1, 1'b0, 4'b0});
    @(negedge clock);
    chk("midrst_no_done", {done, instr_ready}, {1'b0, 1'b1});
    m_nzcv = '0;
    for (int i = 0; i < 60; i++) begin
      logic [31:0] w;
      logic [3:0] f;
      logic p;
      w = $urandom;
      f = 4'($urandom);
      p = cond_pass(w[31:28], m_nzcv);
      if (p && w[23]) m_nzcv = f;
      run($sformatf("rnd%0d", i), w, f, p, p & w[22], m_nzcv);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
